mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Parametrised multi-cycle control sequencer for the teaching processor. It decodes an opcode and function field into per-cycle datapath strobes. Instruction and data memory use a req/ack handshake with a watchdog timeout, unknown opcodes trap, and a retired-instruction counter is provided. It sits between the instruction register/ALU flags and the register file, temp registers, PC, and both memories.

Parameters:
OPC_W, 4, opcode width; bits above [3:0] must be zero or the opcode is illegal.
FUNC_W, 3, function field width; zero-extended or truncated to ALU_SEL_W.
ALU_SEL_W, 4, ALU select width (minimum 3).
TMO_W, 5, timeout counter width.
MEM_TIMEOUT, 16, cycles to wait for an ack; 0 disables the watchdog.
CNT_W, 16, retired-instruction counter width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE
opcode  in  OPC_W  opcode from the IR
func3  in  FUNC_W  function field from the IR
alu_comp  in  2  00 equal, 01 less, 10 greater, 11 reserved
imem_ack  in  1  instruction memory done
dmem_ack  in  1  data memory done
resume  in  1  leave HALT after END
imem_req, ir_l, pc_e  out  1  fetch request, IR load, PC load
pc_sel  out  2  10 = PC+1, 01 = PC+imm, 00 = hold
reg_rd, rs1_e, rs2_e, tr1_l, tr2_l, tr2_sel, imm_e, imm_l, alu_e, reg_wr, rd_e  out  1  datapath strobes
alu_sel  out  ALU_SEL_W  ALU operation
dmem_req, dmem_rd, dmem_addr_l  out  1  data memory controls
output_l, halted, busy  out  1  output latch, in HALT, not in IDLE or HALT
err_code  out  2  00 none, 01 memory timeout, 10 illegal opcode
retired  out  CNT_W  saturating count of completed instructions

Behaviour:
- Reset (async, any state): state goes to IDLE; class, err_code, retired and the timeout counter clear. Every output is 0.
- States: IDLE, FETCH, DECODE, RD1, RD2, IMM, EXEC, MEM, WB, BRT, OUT, HALT.
- Outputs are a Moore decode of state and the latched class. Any strobe not listed for a state is 0.
- IDLE: start -> FETCH. start is ignored in every other state.
- FETCH: imem_req=1. On imem_ack -> DECODE.
- DECODE: ir_l=1, pc_e=1, pc_sel=10. Next state is RD1.
- RD1: reg_rd=1, rs1_e=1, tr1_l=1. The class is latched from opcode this cycle:
  - 0001 R -> RD2
  - 0010 ADDI -> IMM
  - 0011 BNE, 0100 BLT, 0101 BGT -> RD2
  - 0110 LOAD -> IMM
  - 0111 STORE -> RD2
  - 1000 JMP -> BRT
  - 1111 END -> OUT
  - anything else -> HALT with err_code=10
- RD2: reg_rd=1, rs2_e=1, tr2_l=1. STORE -> IMM; all others -> EXEC.
- IMM: imm_e=1, imm_l=1, tr2_sel=1. Next state is EXEC.
- EXEC: alu_e=1.
  - alu_sel is func3 for R, 0 for ADDI/LOAD/STORE, 4 (COMP) for branches.
  - dmem_addr_l=1 for LOAD/STORE.
  - R and ADDI -> WB. LOAD and STORE -> MEM.
  - Branches sample alu_comp in this cycle. Taken -> BRT; not taken -> FETCH.
  - Taken conditions: BNE when alu_comp!=00; BLT when alu_comp==01; BGT when alu_comp==10. alu_comp=11 is never taken.
- MEM: dmem_req=1; dmem_rd=1 for LOAD only. On dmem_ack, LOAD -> WB and STORE -> FETCH.
- WB: reg_wr=1, rd_e=1. Next state is FETCH.
- BRT: imm_e=1, pc_e=1, pc_sel=01. Next state is FETCH.
- OUT: output_l=1. Next state is HALT.
- HALT: halted=1. resume with err_code==00 -> FETCH. When err_code!=00, only reset exits HALT.
- Watchdog:
  - The counter clears on entry to FETCH or MEM and increments each cycle without an ack.
  - If MEM_TIMEOUT!=0 and the count equals MEM_TIMEOUT-1 with no ack -> HALT with err_code=01. The req is deasserted in HALT.
  - An ack in the same cycle as timeout wins.
  - An ack arriving in the very first wait cycle is legal, so zero wait states are allowed.
- Retired counter: increments by 1 on every transition into FETCH from WB, BRT, EXEC (not-taken branch) or MEM (STORE), and on OUT -> HALT. It saturates at all-ones and does not count the IDLE/HALT -> FETCH transitions.
- Fixed cycle counts, with zero-wait acks and counted from FETCH to the next FETCH:
  - R: 7
  - ADDI: 7
  - LOAD: 8
  - STORE: 8
  - taken branch: 7
  - not-taken branch: 6
  - JMP: 5

Test Plan:
- Reset mid-MEM with dmem_req=1 -> all outputs 0 immediately (async), retired=0. After start and an ack one cycle later, imem_req=1 for exactly 2 cycles.
- R ADD (opcode 0001, func3=101), zero-wait acks -> state sequence FETCH, DECODE, RD1, RD2, EXEC, WB, FETCH. alu_sel=0101 in EXEC, reg_wr=1 for one cycle in WB, retired=1.
- BLT (0100) with alu_comp=01 -> BRT with pc_sel=01, pc_e=1. Repeat with alu_comp=10 -> next state FETCH with no pc_e in between. retired=2.
- LOAD (0110) with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_rd=1 for 4 cycles, then WB.
- LOAD with MEM_TIMEOUT=4 and no ack -> HALT after 4 MEM cycles, err_code=01, halted=1. resume is ignored.
- Opcode 1010 -> HALT from RD1 with err_code=10. Separately, END (1111) -> output_l for one cycle, then halted=1 and err_code=00; resume -> FETCH.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - IR/flag inputs, memory handshakes and datapath strobes of mc_control_unit
// master = sequencer side, slave = datapath/memory side.
interface mc_control_unit_if #(
  parameter int OPC_W     = 4,
  parameter int FUNC_W    = 3,
  parameter int ALU_SEL_W = 4,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [OPC_W-1:0]     opcode;
  logic [FUNC_W-1:0]    func3;
  logic [1:0]           alu_comp;
  logic                 imem_ack;
  logic                 dmem_ack;
  logic                 resume;
  logic                 imem_req, ir_l, pc_e;
  logic [1:0]           pc_sel;
  logic                 reg_rd, rs1_e, rs2_e, tr1_l, tr2_l, tr2_sel;
  logic                 imm_e, imm_l, alu_e, reg_wr, rd_e;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 dmem_req, dmem_rd, dmem_addr_l;
  logic                 output_l, halted, busy;
  logic [1:0]           err_code;
  logic [CNT_W-1:0]     retired;

  modport master (
    input  start, opcode, func3, alu_comp, imem_ack, dmem_ack, resume,
    output imem_req, ir_l, pc_e, pc_sel, reg_rd, rs1_e, rs2_e, tr1_l, tr2_l, tr2_sel,
           imm_e, imm_l, alu_e, reg_wr, rd_e, alu_sel, dmem_req, dmem_rd, dmem_addr_l,
           output_l, halted, busy, err_code, retired
  );

  modport slave (
    output start, opcode, func3, alu_comp, imem_ack, dmem_ack, resume,
    input  imem_req, ir_l, pc_e, pc_sel, reg_rd, rs1_e, rs2_e, tr1_l, tr2_l, tr2_sel,
           imm_e, imm_l, alu_e, reg_wr, rd_e, alu_sel, dmem_req, dmem_rd, dmem_addr_l,
           output_l, halted, busy, err_code, retired
  );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle control sequencer with memory watchdog and retire counter
// Outputs are a Moore decode of state and the instruction class latched in RD1.
module mc_control_unit #(
  parameter int OPC_W       = 4,
  parameter int FUNC_W      = 3,
  parameter int ALU_SEL_W   = 4,
  parameter int TMO_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          reset_n,
  mc_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RD1, S_RD2, S_IMM,
    S_EXEC, S_MEM, S_WB, S_BRT, S_OUT, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_ADDI, C_BNE, C_BLT, C_BGT, C_LOAD, C_STORE, C_JMP, C_END, C_ILL
  } class_e;

  localparam bit                   TMO_EN   = (MEM_TIMEOUT != 0);
  localparam int                   TMO_LIM  = TMO_EN ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TMO_W-1:0]     TMO_MAX  = TMO_W'(TMO_LIM);
  localparam logic [ALU_SEL_W-1:0] ALU_COMP = ALU_SEL_W'(4);

  state_e            state_q, state_d;
  class_e            cls_q, cls_d, cls_dec;
  logic [1:0]        err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              tmo_hit, taken, retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILL;
      err_q     <= 2'b00;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  // Any set bit above the 4-bit opcode field makes the instruction illegal.
  always_comb begin
    cls_dec = C_ILL;
    if ((bus.opcode >> 4) == '0) begin
      case (bus.opcode[3:0])
        4'b0001: cls_dec = C_R;
        4'b0010: cls_dec = C_ADDI;
        4'b0011: cls_dec = C_BNE;
        4'b0100: cls_dec = C_BLT;
        4'b0101: cls_dec = C_BGT;
        4'b0110: cls_dec = C_LOAD;
        4'b0111: cls_dec = C_STORE;
        4'b1000: cls_dec = C_JMP;
        4'b1111: cls_dec = C_END;
        default: cls_dec = C_ILL;
      endcase
    end
  end

  // alu_comp = 11 is reserved and never takes a branch, not even BNE.
  always_comb begin
    taken = 1'b0;
    case (cls_q)
      C_BNE:   taken = (bus.alu_comp == 2'b01) || (bus.alu_comp == 2'b10);
      C_BLT:   taken = (bus.alu_comp == 2'b01);
      C_BGT:   taken = (bus.alu_comp == 2'b10);
      default: taken = 1'b0;
    endcase
  end

  assign tmo_hit = TMO_EN && (tmo_q == TMO_MAX);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) state_d = S_DECODE;
        else if (tmo_hit) begin
          state_d = S_HALT;
          err_d   = 2'b01;
        end
      end
      S_DECODE: state_d = S_RD1;
      S_RD1: begin
        cls_d = cls_dec;
        case (cls_dec)
          C_R, C_BNE, C_BLT, C_BGT, C_STORE: state_d = S_RD2;
          C_ADDI, C_LOAD:                    state_d = S_IMM;
          C_JMP:                             state_d = S_BRT;
          C_END:                             state_d = S_OUT;
          default: begin
            state_d = S_HALT;
            err_d   = 2'b10;
          end
        endcase
      end
      S_RD2:    state_d = (cls_q == C_STORE) ? S_IMM : S_EXEC;
      S_IMM:    state_d = S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_R, C_ADDI:     state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = taken ? S_BRT : S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        else if (tmo_hit) begin
          state_d = S_HALT;
          err_d   = 2'b01;
        end
      end
      S_WB, S_BRT: state_d = S_FETCH;
      S_OUT:       state_d = S_HALT;
      S_HALT:      if (bus.resume && err_q == 2'b00) state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  // Watchdog restarts on entry to a wait state and counts unacknowledged cycles.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
      tmo_d = '0;
    else if ((state_q == S_FETCH && !bus.imem_ack) || (state_q == S_MEM && !bus.dmem_ack))
      tmo_d = tmo_q + 1'b1;
  end

  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH &&
        (state_q == S_WB || state_q == S_BRT || state_q == S_EXEC || state_q == S_MEM))
      retire = 1'b1;
    if (state_q == S_OUT) retire = 1'b1;
    retired_d = retired_q;
    if (retire && retired_q != '1) retired_d = retired_q + 1'b1;
  end

  always_comb begin
    bus.imem_req    = (state_q == S_FETCH);
    bus.ir_l        = (state_q == S_DECODE);
    bus.pc_e        = (state_q == S_DECODE) || (state_q == S_BRT);
    bus.pc_sel      = (state_q == S_DECODE) ? 2'b10 : (state_q == S_BRT) ? 2'b01 : 2'b00;
    bus.reg_rd      = (state_q == S_RD1) || (state_q == S_RD2);
    bus.rs1_e       = (state_q == S_RD1);
    bus.tr1_l       = (state_q == S_RD1);
    bus.rs2_e       = (state_q == S_RD2);
    bus.tr2_l       = (state_q == S_RD2);
    bus.tr2_sel     = (state_q == S_IMM);
    bus.imm_l       = (state_q == S_IMM);
    bus.imm_e       = (state_q == S_IMM) || (state_q == S_BRT);
    bus.alu_e       = (state_q == S_EXEC);
    bus.alu_sel     = '0;
    if (state_q == S_EXEC) begin
      if (cls_q == C_R) bus.alu_sel = ALU_SEL_W'(bus.func3);
      else if (cls_q == C_BNE || cls_q == C_BLT || cls_q == C_BGT) bus.alu_sel = ALU_COMP;
    end
    bus.dmem_addr_l = (state_q == S_EXEC) && (cls_q == C_LOAD || cls_q == C_STORE);
    bus.dmem_req    = (state_q == S_MEM);
    bus.dmem_rd     = (state_q == S_MEM) && (cls_q == C_LOAD);
    bus.reg_wr      = (state_q == S_WB);
    bus.rd_e        = (state_q == S_WB);
    bus.output_l    = (state_q == S_OUT);
    bus.halted      = (state_q == S_HALT);
    bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    bus.err_code    = err_q;
    bus.retired     = retired_q;
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed self-checking bench for mc_control_unit
// State is inferred from the unique strobe each state raises.
module tb_mc_control_unit;
  localparam int OPC_W = 4, FUNC_W = 3, ALU_SEL_W = 4, TMO_W = 5, MEM_TIMEOUT = 4, CNT_W = 16;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_RD1 = 3, ST_RD2 = 4, ST_IMM = 5;
  localparam int ST_EXEC = 6, ST_MEM = 7, ST_WB = 8, ST_BRT = 9, ST_OUT = 10, ST_HALT = 11, ST_BAD = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int q[$];

  mc_control_unit_if #(.OPC_W(OPC_W), .FUNC_W(FUNC_W), .ALU_SEL_W(ALU_SEL_W), .CNT_W(CNT_W)) bus ();

  mc_control_unit #(
    .OPC_W(OPC_W), .FUNC_W(FUNC_W), .ALU_SEL_W(ALU_SEL_W),
    .TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int obs_state();
    if (bus.halted)                        return ST_HALT;
    if (bus.imem_req)                      return ST_FETCH;
    if (bus.ir_l)                          return ST_DECODE;
    if (bus.tr1_l)                         return ST_RD1;
    if (bus.tr2_l)                         return ST_RD2;
    if (bus.imm_l)                         return ST_IMM;
    if (bus.alu_e)                         return ST_EXEC;
    if (bus.dmem_req)                      return ST_MEM;
    if (bus.reg_wr)                        return ST_WB;
    if (bus.output_l)                      return ST_OUT;
    if (bus.pc_e && bus.pc_sel == 2'b01)   return ST_BRT;
    if (!bus.busy)                         return ST_IDLE;
    return ST_BAD;
  endfunction

  function automatic logic [43:0] all_out();
    return {bus.imem_req, bus.ir_l, bus.pc_e, bus.pc_sel, bus.reg_rd, bus.rs1_e, bus.rs2_e,
            bus.tr1_l, bus.tr2_l, bus.tr2_sel, bus.imm_e, bus.imm_l, bus.alu_e, bus.reg_wr,
            bus.rd_e, bus.alu_sel, bus.dmem_req, bus.dmem_rd, bus.dmem_addr_l, bus.output_l,
            bus.halted, bus.busy, bus.err_code, bus.retired};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic walk(input string tag, input int seq[$]);
    foreach (seq[i]) begin
      tick();
      chk($sformatf("%s_step%0d", tag, i), 64'(obs_state()), 64'(seq[i]));
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0; bus.opcode = '0; bus.func3 = '0; bus.alu_comp = 2'b00;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.resume = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", 64'(all_out()), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_hold", 64'(obs_state()), ST_IDLE);

    // R ADD, fetch ack one cycle late
    bus.opcode = 4'b0001; bus.func3 = 3'b101; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    chk("r_fetch1", 64'(obs_state()), ST_FETCH);
    tick();
    chk("r_fetch2", 64'(obs_state()), ST_FETCH);
    bus.imem_ack = 1'b1;
    q = '{ST_DECODE}; walk("r_dec", q);
    chk("r_decode_pc", 64'({bus.pc_e, bus.pc_sel}), 64'b110);
    q = '{ST_RD1, ST_RD2, ST_EXEC}; walk("r_rd", q);
    chk("r_alu_sel", 64'(bus.alu_sel), 64'b0101);
    q = '{ST_WB}; walk("r_wb", q);
    chk("r_wb_strobes", 64'({bus.reg_wr, bus.rd_e}), 64'b11);
    q = '{ST_FETCH}; walk("r_end", q);
    chk("r_retired", 64'(bus.retired), 64'd1);

    // BLT taken
    bus.opcode = 4'b0100; bus.alu_comp = 2'b01;
    q = '{ST_DECODE, ST_RD1, ST_RD2, ST_EXEC}; walk("blt_t", q);
    chk("blt_alu_sel", 64'(bus.alu_sel), 64'd4);
    q = '{ST_BRT}; walk("blt_t_brt", q);
    chk("blt_brt_pc", 64'({bus.pc_e, bus.pc_sel}), 64'b101);
    q = '{ST_FETCH}; walk("blt_t_end", q);
    chk("blt_t_retired", 64'(bus.retired), 64'd2);

    // BLT not taken, then BNE with reserved compare code
    bus.alu_comp = 2'b10;
    q = '{ST_DECODE, ST_RD1, ST_RD2, ST_EXEC, ST_FETCH}; walk("blt_nt", q);
    chk("blt_nt_pc_e", 64'(bus.pc_e), 64'd0);
    chk("blt_nt_retired", 64'(bus.retired), 64'd3);
    bus.opcode = 4'b0011; bus.alu_comp = 2'b11;
    q = '{ST_DECODE, ST_RD1, ST_RD2, ST_EXEC, ST_FETCH}; walk("bne_11", q);
    chk("bne_11_retired", 64'(bus.retired), 64'd4);

    // LOAD, ack in the fourth MEM cycle (same cycle as the timeout)
    bus.opcode = 4'b0110; bus.alu_comp = 2'b00;
    q = '{ST_DECODE, ST_RD1, ST_IMM}; walk("ld", q);
    chk("ld_imm_strobes", 64'({bus.tr2_sel, bus.imm_e}), 64'b11);
    q = '{ST_EXEC}; walk("ld_exec", q);
    chk("ld_exec_ctl", 64'({bus.alu_sel, bus.dmem_addr_l}), 64'b00001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ld_mem_req%0d", i), 64'({bus.dmem_req, bus.dmem_rd}), 64'b11);
    end
    bus.dmem_ack = 1'b1;
    q = '{ST_WB}; walk("ld_wb", q);
    bus.dmem_ack = 1'b0;
    q = '{ST_FETCH}; walk("ld_end", q);
    chk("ld_retired", 64'(bus.retired), 64'd5);

    // STORE, async reset while in MEM
    bus.opcode = 4'b0111;
    q = '{ST_DECODE, ST_RD1, ST_RD2, ST_IMM, ST_EXEC, ST_MEM}; walk("st", q);
    chk("st_mem_ctl", 64'({bus.dmem_req, bus.dmem_rd}), 64'b10);
    #2 reset_n = 1'b0;
    #1 chk("st_async_reset", 64'(all_out()), 64'd0);
    tick();
    reset_n = 1'b1;
    chk("st_after_reset", 64'(obs_state()), ST_IDLE);

    // JMP
    bus.opcode = 4'b1000; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    q = '{ST_DECODE, ST_RD1, ST_BRT, ST_FETCH}; walk("jmp", q);
    chk("jmp_retired", 64'(bus.retired), 64'd1);

    // LOAD with no ack: watchdog fires after 4 MEM cycles
    bus.opcode = 4'b0110;
    q = '{ST_DECODE, ST_RD1, ST_IMM, ST_EXEC, ST_MEM, ST_MEM, ST_MEM, ST_MEM, ST_HALT}; walk("tmo", q);
    chk("tmo_err", 64'({bus.err_code, bus.dmem_req, bus.busy}), 64'b0100);
    bus.resume = 1'b1;
    q = '{ST_HALT}; walk("tmo_resume", q);
    bus.resume = 1'b0;
    chk("tmo_retired", 64'(bus.retired), 64'd1);

    // Illegal opcode
    pulse_reset();
    bus.opcode = 4'b1010; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    q = '{ST_DECODE, ST_RD1, ST_HALT}; walk("ill", q);
    chk("ill_err", 64'(bus.err_code), 64'b10);
    chk("ill_retired", 64'(bus.retired), 64'd0);

    // END then resume
    pulse_reset();
    bus.opcode = 4'b1111; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    q = '{ST_DECODE, ST_RD1, ST_OUT, ST_HALT}; walk("end", q);
    chk("end_halt", 64'({bus.halted, bus.err_code, bus.output_l}), 64'b1000);
    chk("end_retired", 64'(bus.retired), 64'd1);
    bus.resume = 1'b1;
    q = '{ST_FETCH}; walk("end_resume", q);
    bus.resume = 1'b0;
    chk("end_resume_retired", 64'(bus.retired), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
